// File: rtl/data_ram_arbiter_if.sv
// Bus bundle between the two data-RAM masters, the arbiter and the single-port data RAM.
// The master modport is the environment side: both masters plus the RAM's read port.
interface data_ram_arbiter_if;
    logic        m0_req;
    logic        m0_we;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_gnt;
    logic        m0_rvalid;
    logic [31:0] m0_rdata;

    logic        m1_req;
    logic        m1_we;
    logic        m1_lock;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_gnt;
    logic        m1_rvalid;
    logic [31:0] m1_rdata;

    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
        output ram_dout,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  ram_we, ram_addr, ram_din
    );

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
        input  ram_dout,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output ram_we, ram_addr, ram_din
    );
endinterface

// File: rtl/data_ram_arbiter.sv
// Round-robin arbiter sharing the data RAM between the MEM stage (m0) and the
// context-save engine (m1), with a bounded lock for m1 and a one-cycle read return.
module data_ram_arbiter #(
    parameter int MAX_LOCK = 4
) (
    input logic                clk,
    input logic                rst_n,
    data_ram_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(MAX_LOCK);

    logic             last_gnt;
    logic             prev_m1;
    logic [CNT_W-1:0] lock_cnt;
    logic [1:0]       rd_pend;
    logic [31:0]      rdata_q;

    logic hold;
    logic gnt0;
    logic gnt1;
    logic rd0;
    logic rd1;

    // m1 keeps the RAM while it locks, bounded only when m0 is actually waiting.
    assign hold = bus.m1_req & bus.m1_lock & prev_m1 &
                  ((lock_cnt < LOCK_MAX) | ~bus.m0_req);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            if (hold) begin
                gnt1 = 1'b1;
            end else if (bus.m0_req && bus.m1_req) begin
                gnt0 = last_gnt;
                gnt1 = ~last_gnt;
            end else if (bus.m0_req) begin
                gnt0 = 1'b1;
            end else if (bus.m1_req) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign rd0 = gnt0 & ~bus.m0_we;
    assign rd1 = gnt1 & ~bus.m1_we;

    always_comb begin
        bus.ram_we   = 1'b0;
        bus.ram_addr = '0;
        bus.ram_din  = '0;
        if (gnt0) begin
            bus.ram_we   = bus.m0_we;
            bus.ram_addr = bus.m0_addr;
            bus.ram_din  = bus.m0_wdata;
        end else if (gnt1) begin
            bus.ram_we   = bus.m1_we;
            bus.ram_addr = bus.m1_addr;
            bus.ram_din  = bus.m1_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= 1'b1;
            prev_m1  <= 1'b0;
            lock_cnt <= '0;
            rd_pend  <= 2'b00;
            rdata_q  <= '0;
        end else begin
            if (gnt0 | gnt1) begin
                last_gnt <= gnt1;
            end
            prev_m1 <= gnt1;
            if (!gnt1) begin
                lock_cnt <= '0;
            end else if (lock_cnt != LOCK_MAX) begin
                lock_cnt <= lock_cnt + 1'b1;
            end
            // ram_dout settles at the negedge of the grant cycle.
            rd_pend <= {rd1, rd0};
            if (rd0 | rd1) begin
                rdata_q <= bus.ram_dout;
            end
        end
    end

    assign bus.m0_gnt    = gnt0;
    assign bus.m1_gnt    = gnt1;
    assign bus.m0_rvalid = rd_pend[0];
    assign bus.m1_rvalid = rd_pend[1];
    assign bus.m0_rdata  = rdata_q;
    assign bus.m1_rdata  = rdata_q;
endmodule
